// File: rtl/led_pulse_stretch_if.sv
// rtl/led_pulse_stretch_if.sv - event strobe in, LED drive and queue status out
interface led_pulse_stretch_if;
  logic       evt;
  logic       led_out;
  logic       busy;
  logic [3:0] pending;
  logic       overflow;

  modport master (output evt, input led_out, busy, pending, overflow);
  modport slave  (input evt, output led_out, busy, pending, overflow);
endinterface

// File: rtl/led_pulse_stretch.sv
// rtl/led_pulse_stretch.sv - stretches single-cycle events into fixed-length LED blinks with a queue
// LED_PULSE_STRETCH_QUEUE_EN selects a 15-deep pending counter; otherwise a single pending flag.
module led_pulse_stretch #(
  parameter int CLK_HZ = 100_000_000,
  parameter int ON_MS  = 50,
  parameter int OFF_MS = 50
) (
  input logic               clk,
  input logic               rst,
  led_pulse_stretch_if.slave bus
);

  localparam int ON_CYC  = (CLK_HZ / 1000) * ON_MS;
  localparam int OFF_CYC = (CLK_HZ / 1000) * OFF_MS;
  localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYC - 1);

`ifdef LED_PULSE_STRETCH_QUEUE_EN
  localparam int PW = 4;
`else
  localparam int PW = 1;
`endif

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [PW-1:0] pend_q, pend_next;
  logic          led_q;
  logic          ovf_q;
  logic          ovf_set;
  logic          consume;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pend_next  = pend_q;
    ovf_set    = 1'b0;
    consume    = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (bus.evt) state_next = ON;
      end
      ON: begin
        if (cnt == ON_LAST) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == OFF_LAST) begin
          cnt_next = '0;
          // A strobe landing in the last gap cycle chains straight into the next blink.
          if (pend_q != '0 || bus.evt) begin
            state_next = ON;
            consume    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // The strobe that starts a blink from IDLE is shown directly and never queued.
    if (consume) begin
      pend_next = pend_q - PW'(1) + PW'(bus.evt);
    end else if (bus.evt && state != IDLE) begin
      if (pend_q == '1) ovf_set = 1'b1;
      else              pend_next = pend_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      pend_q <= '0;
      led_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      pend_q <= pend_next;
      led_q  <= (state_next == ON);
      ovf_q  <= ovf_q | ovf_set;
    end
  end

  assign bus.led_out  = led_q;
  assign bus.busy     = (state != IDLE);
  assign bus.pending  = 4'(pend_q);
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// tb/tb_led_pulse_stretch.sv - table-driven bench for led_pulse_stretch (ON_CYC=20, OFF_CYC=10)
module tb_led_pulse_stretch;

  localparam int ON_CYC  = 20;
  localparam int OFF_CYC = 10;
`ifdef LED_PULSE_STRETCH_QUEUE_EN
  localparam int PMAX = 15;
`else
  localparam int PMAX = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_pulse_stretch_if bus ();

  led_pulse_stretch #(.CLK_HZ(10_000), .ON_MS(2), .OFF_MS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       evt;
    int         n;
    logic       led;
    logic       busy;
    logic [3:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  int   blinks, hi_len, lo_len;
  logic prev_led;

  function automatic void add(input logic r, input logic e, input int n,
                              input logic l, input logic b, input logic [3:0] p, input logic o);
    vecs.push_back('{r, e, n, l, b, p, o});
  endfunction

  task automatic chk(input string name, input int idx, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s at %0d: got %0d expected %0d", name, idx, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon();
    if (bus.led_out) begin
      if (!prev_led) begin
        blinks++;
        if (blinks > 1) chk("gap_len", blinks, lo_len, OFF_CYC);
        lo_len = 0;
      end
      hi_len++;
    end else begin
      if (prev_led) begin
        chk("on_len", blinks, hi_len, ON_CYC);
        hi_len = 0;
      end
      lo_len++;
    end
    prev_led = bus.led_out;
  endtask

  initial begin
    rst     = 1'b1;
    bus.evt = 1'b0;

    // reset overrides a simultaneous strobe
    add(1, 1, 2, 0, 0, 0, 0);
    // single event: 20 on, 10 gap, then idle
    add(0, 1, 1, 1, 1, 0, 0);
    add(0, 0, 19, 1, 1, 0, 0);
    add(0, 0, 10, 0, 1, 0, 0);
    add(0, 0, 3, 0, 0, 0, 0);
    // strobe only in the last gap cycle chains into ON without queuing
    add(0, 1, 1, 1, 1, 0, 0);
    add(0, 0, 19, 1, 1, 0, 0);
    add(0, 0, 10, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1, 0, 0);
    add(0, 0, 19, 1, 1, 0, 0);
    add(0, 0, 10, 0, 1, 0, 0);
    add(0, 0, 2, 0, 0, 0, 0);
`ifdef LED_PULSE_STRETCH_QUEUE_EN
    // three queued events during ON -> four blinks, pending counts down at each gap end
    add(0, 1, 1, 1, 1, 0, 0);
    add(0, 0, 2, 1, 1, 0, 0);
    add(0, 1, 1, 1, 1, 1, 0);
    add(0, 1, 1, 1, 1, 2, 0);
    add(0, 1, 1, 1, 1, 3, 0);
    add(0, 0, 14, 1, 1, 3, 0);
    add(0, 0, 10, 0, 1, 3, 0);
    add(0, 0, 20, 1, 1, 2, 0);
    add(0, 0, 10, 0, 1, 2, 0);
    add(0, 0, 20, 1, 1, 1, 0);
    add(0, 0, 10, 0, 1, 1, 0);
    add(0, 0, 20, 1, 1, 0, 0);
    add(0, 0, 10, 0, 1, 0, 0);
    add(0, 0, 3, 0, 0, 0, 0);
    // reset in ON cycle 5 with two queued events
    add(0, 1, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 1, 1, 0);
    add(0, 1, 1, 1, 1, 2, 0);
    add(0, 0, 2, 1, 1, 2, 0);
`else
    // two events during ON: second is dropped, sticky overflow, two blinks
    add(0, 1, 1, 1, 1, 0, 0);
    add(0, 0, 2, 1, 1, 0, 0);
    add(0, 1, 1, 1, 1, 1, 0);
    add(0, 1, 1, 1, 1, 1, 1);
    add(0, 0, 15, 1, 1, 1, 1);
    add(0, 0, 10, 0, 1, 1, 1);
    add(0, 0, 20, 1, 1, 0, 1);
    add(0, 0, 10, 0, 1, 0, 1);
    add(0, 0, 3, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0);
    // reset in ON cycle 5 with a queued event
    add(0, 1, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 1, 1, 0);
    add(0, 0, 3, 1, 1, 1, 0);
`endif
    add(1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 60, 0, 0, 0, 0);

    foreach (vecs[v]) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        rst     = vecs[v].rst;
        bus.evt = vecs[v].evt;
        step();
        chk("led_out",  v, bus.led_out,  vecs[v].led);
        chk("busy",     v, bus.busy,     vecs[v].busy);
        chk("pending",  v, bus.pending,  vecs[v].pend);
        chk("overflow", v, bus.overflow, vecs[v].ovf);
      end
    end

    // evt held 20 cycles in IDLE: queue saturates, excess dropped, PMAX+1 blinks
    rst      = 1'b0;
    blinks   = 0;
    hi_len   = 0;
    lo_len   = 0;
    prev_led = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.evt = 1'b1;
      step();
      mon();
      chk("sat_pending",  i, bus.pending,  (i < PMAX) ? i : PMAX);
      chk("sat_overflow", i, bus.overflow, (i > PMAX) ? 1 : 0);
    end
    bus.evt = 1'b0;
    for (int c = 0; c < 3000 && bus.busy; c++) begin
      step();
      mon();
    end
    chk("sat_idle",     0, bus.busy,     0);
    chk("sat_blinks",   0, blinks,       PMAX + 1);
    chk("sat_pend_end", 0, bus.pending,  0);
    chk("sat_ovf_end",  0, bus.overflow, 1);

    rst = 1'b1;
    step();
    chk("ovf_cleared", 0, bus.overflow, 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
